// File: rtl/cia_pipe_adder_if.sv
// Operand/result handshake bundle for cia_pipe_adder: valid/ready on the
// operand side and on the result side.
interface cia_pipe_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cia_pipe_adder.sv
// Pipelined carry-increment adder: one SEG-bit segment resolved per stage, with
// collapsing valid/ready flow control. Define CIA_PIPE_SUB_EN to honour bus.sub.
module cia_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cia_pipe_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / SEG;

    // Returns {segment carry-out, carry into segment MSB, segment sum}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] sa,
                                               input logic [SEG-1:0] sb,
                                               input logic           ci);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] s;
        logic           gp;
        logic           pp;
        logic           cmsb;
        p    = sa ^ sb;
        g    = sa & sb;
        gp   = 1'b0;
        pp   = 1'b1;
        cmsb = ci;
        s    = '0;
        for (int i = 0; i < SEG; i++) begin
            cmsb = gp | (pp & ci);
            s[i] = p[i] ^ cmsb;
            gp   = g[i] | (p[i] & gp);
            pp   = pp & p[i];
        end
        return {gp | (pp & ci), cmsb, s};
    endfunction

    logic [WIDTH-1:0]  a_q    [STAGES];
    logic [WIDTH-1:0]  b_q    [STAGES];
    logic [WIDTH-1:0]  s_q    [STAGES];
    logic [WIDTH-1:0]  a_d    [STAGES];
    logic [WIDTH-1:0]  b_d    [STAGES];
    logic [WIDTH-1:0]  s_d    [STAGES];
    logic [WIDTH-1:0]  a_in_s [STAGES];
    logic [WIDTH-1:0]  b_in_s [STAGES];
    logic [WIDTH-1:0]  s_in_s [STAGES];
    logic [SEG+1:0]    seg_s  [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_in_s;
    logic [STAGES-1:0] vin_s;
    logic [STAGES-1:0] take_s;
    logic [STAGES-1:0] ready_s;
    logic [STAGES-1:0] ready_dn_s;
    logic              ovf_q;
    logic [WIDTH-1:0]  b_eff_s;
    logic              cin_eff_s;

`ifdef CIA_PIPE_SUB_EN
    // Subtraction is a + ~b + ~cin, so cin acts as borrow-in and cout as no-borrow.
    assign b_eff_s   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff_s = bus.sub ? ~bus.cin : bus.cin;
`else
    logic unused_sub_s;
    assign unused_sub_s = bus.sub;
    assign b_eff_s      = bus.b;
    assign cin_eff_s    = bus.cin;
`endif

    // Ready of stage k is the OR of every downstream hole and out_ready.
    always_comb begin
        logic rdy;
        rdy        = 1'b0;
        ready_s    = '0;
        ready_dn_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            rdy = bus.out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                rdy = rdy | ~v_q[j];
            end
            ready_dn_s[k] = rdy;
            ready_s[k]    = ~v_q[k] | rdy;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in_s[k] = bus.a;
            assign b_in_s[k] = b_eff_s;
            assign s_in_s[k] = '0;
            assign c_in_s[k] = cin_eff_s;
            assign vin_s[k]  = bus.in_valid;
        end else begin : g_body
            assign a_in_s[k] = a_q[k-1];
            assign b_in_s[k] = b_q[k-1];
            assign s_in_s[k] = s_q[k-1];
            assign c_in_s[k] = c_q[k-1];
            assign vin_s[k]  = v_q[k-1];
        end
        assign seg_s[k]  = seg_add(a_in_s[k][SEG-1:0], b_in_s[k][SEG-1:0], c_in_s[k]);
        // Operands shift down as segments are consumed; sums shift in from the top.
        assign a_d[k]    = a_in_s[k] >> SEG;
        assign b_d[k]    = b_in_s[k] >> SEG;
        assign s_d[k]    = (s_in_s[k] >> SEG) | (WIDTH'(seg_s[k][SEG-1:0]) << (WIDTH - SEG));
        assign take_s[k] = vin_s[k] & ready_s[k];
    end

    // Stage valid: refilled on a transfer in, cleared when drained downstream.
    always_comb begin
        v_d = take_s | (v_q & ~ready_dn_s);
    end

    // Pipeline registers, loaded only on a transfer into their stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                if (take_s[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= seg_s[k][SEG+1];
                end
            end
            if (take_s[STAGES-1]) begin
                ovf_q <= seg_s[STAGES-1][SEG+1] ^ seg_s[STAGES-1][SEG];
            end
        end
    end

    assign bus.in_ready  = ready_s[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cia_pipe_adder.sv
// Self-checking bench for cia_pipe_adder (WIDTH=16, SEG=4) against an
// arithmetic reference model and an in-order result queue.
module tb_cia_pipe_adder;
    localparam int W  = 16;
    localparam int S  = 4;
    localparam int ST = W / S;
`ifdef CIA_PIPE_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [W+1:0] exp_q [$];

    cia_pipe_adder_if #(.WIDTH(W)) bus ();

    cia_pipe_adder #(.WIDTH(W), .SEG(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference result {cout, ovf, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         ci;
        logic         ovf;
        bb = (sub & SUB_EN) ? ~b : b;
        ci = (sub & SUB_EN) ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ovf, full[W-1:0]};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = c;
        bus.sub       = s;
        bus.out_ready = ordy;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic note_accept();
        if (rst_n && bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_op(bus.a, bus.b, bus.cin, bus.sub));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'($urandom()), W'($urandom()), 1'b1, 1'b0, 1'b1);
            next_edge();
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.cout, bus.ovf, bus.sum} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b cout=%b ovf=%b sum=%h, want all 0",
                         bus.out_valid, bus.cout, bus.ovf, bus.sum);
            end
        end
        next_edge();
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        next_edge();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
        end
        next_edge();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFF};
        logic [W-1:0] tb [4] = '{16'h4321, 16'h0001, 16'h0001, 16'h0000};
        logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [4] = '{16'h5555, 16'h0000, 16'h8000, 16'h0000};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            int   lat;
            logic got;
            drive(1'b1, ta[i], tb[i], tc[i], 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_in_ready[%0d]: got %b, want 1", i, bus.in_ready);
            end
            next_edge();
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                @(negedge clk);
                lat++;
                if (bus.out_valid === 1'b1) got = 1'b1;
                else next_edge();
            end
            checks++;
            if (!got || lat != ST) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d cycles (seen=%b), want %0d", i, lat, got, ST);
            end
            checks++;
            if ({bus.sum, bus.cout, bus.ovf} !== {es[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL dir_result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, bus.sum, bus.cout, bus.ovf, es[i], ec[i], eo[i]);
            end
            next_edge();
        end
    endtask

    task automatic test_back_to_back();
        int n_out = 0, cyc = 0, first = -1, last = -1, drops = 0;
        logic [W+1:0] want;
        exp_q.delete();
        for (int i = 0; i < 100 + 20; i++) begin
            if (i < 100) drive(1'b1, W'($urandom()), W'($urandom()), 1'($urandom()), 1'b0, 1'b1);
            else         drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            cyc++;
            if (i < 100 && bus.in_ready !== 1'b1) drops++;
            note_accept();
            if (bus.out_valid === 1'b1) begin
                n_out++;
                if (first < 0) first = cyc;
                last = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got sum=%h with no result pending", bus.sum);
                end else begin
                    want = exp_q.pop_front();
                    if ({bus.cout, bus.ovf, bus.sum} !== want) begin
                        errors++;
                        $display("FAIL b2b_data: got {cout,ovf,sum}=%h, want %h", {bus.cout, bus.ovf, bus.sum}, want);
                    end
                end
            end
            next_edge();
        end
        checks++;
        if (drops != 0 || n_out != 100 || (last - first + 1) != 100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_throughput: got stalls=%0d outputs=%0d span=%0d left=%0d, want 0/100/100/0",
                     drops, n_out, last - first + 1, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int n_acc, n_out;
        logic [W+1:0] want;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, W'($urandom()), W'($urandom()), 1'($urandom()), 1'b0, 1'b0);
            @(negedge clk);
            note_accept();
            if (bus.out_valid === 1'b1) begin
                checks++;
                if ({bus.cout, bus.ovf, bus.sum} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall_hold: got %h, want %h", {bus.cout, bus.ovf, bus.sum}, exp_q[0]);
                end
            end
            next_edge();
        end
        n_acc = exp_q.size();
        checks++;
        if (n_acc != ST) begin
            errors++;
            $display("FAIL stall_accepts: got %0d, want %0d", n_acc, ST);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: got in_ready=%b out_valid=%b, want 0/1", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_passthru_ready: got %b, want 1", bus.in_ready);
        end
        note_accept();
        n_out = 0;
        for (int i = 0; i < 20 && (i == 0 || exp_q.size() != 0); i++) begin
            if (i > 0) begin
                drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                @(negedge clk);
            end
            if (bus.out_valid === 1'b1) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_extra: got sum=%h with no result pending", bus.sum);
                end else begin
                    want = exp_q.pop_front();
                    if ({bus.cout, bus.ovf, bus.sum} !== want) begin
                        errors++;
                        $display("FAIL drain_data: got %h, want %h", {bus.cout, bus.ovf, bus.sum}, want);
                    end
                end
            end
            next_edge();
        end
        checks++;
        if (n_out != ST + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_count: got %0d results, %0d left, want %0d/0", n_out, exp_q.size(), ST + 1);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'($urandom()), W'($urandom()), 1'b0, 1'b0, 1'b0);
            next_edge();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        next_edge();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_flush: got out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
        next_edge();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
            next_edge();
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d valid cycles, want 0", stale);
        end
    endtask

    task automatic test_random_backpressure();
        logic [W+1:0] want;
        exp_q.delete();
        for (int i = 0; i < 340; i++) begin
            if (i < 300)
                drive(1'($urandom_range(0, 3) != 0), W'($urandom()), W'($urandom()), 1'($urandom()),
                      1'($urandom()), 1'($urandom()));
            else
                drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            note_accept();
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got sum=%h with no result pending", bus.sum);
                end else begin
                    want = exp_q[0];
                    if ({bus.cout, bus.ovf, bus.sum} !== want) begin
                        errors++;
                        $display("FAIL rand_data: got %h, want %h", {bus.cout, bus.ovf, bus.sum}, want);
                    end
                    if (bus.out_ready) exp_q.pop_front();
                end
            end
            next_edge();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got %0d results left, want 0", exp_q.size());
        end
    endtask

`ifdef CIA_PIPE_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ta [2] = '{16'h0005, 16'h8000};
        logic [W-1:0] tb [2] = '{16'h0007, 16'h0001};
        logic [W+1:0] ew [2] = '{{1'b0, 1'b0, 16'hFFFE}, {1'b1, 1'b1, 16'h7FFF}};
        for (int i = 0; i < 2; i++) begin
            int lat;
            drive(1'b1, ta[i], tb[i], 1'b0, 1'b1, 1'b1);
            next_edge();
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && lat < 20) begin
                next_edge();
                @(negedge clk);
                lat++;
            end
            checks++;
            if ({bus.cout, bus.ovf, bus.sum} !== ew[i] || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sub_result[%0d]: got valid=%b {cout,ovf,sum}=%h, want %h",
                         i, bus.out_valid, {bus.cout, bus.ovf, bus.sum}, ew[i]);
            end
            next_edge();
        end
    endtask
`endif

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random_backpressure();
`ifdef CIA_PIPE_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cia_pipe_adder.md
# cia_pipe_adder

Parametrised, pipelined carry-increment adder with valid/ready flow control. Splits a WIDTH-bit addition into WIDTH/SEG segments; each pipeline stage resolves one segment using segment-local generate/propagate prefixes and the registered carry from the previous stage. Throughput one operation per cycle, latency WIDTH/SEG cycles. Sits in the arithmetic datapath wherever a wide add must close timing at high clock rates.

## Interface
- WIDTH, 32, operand and sum width; must be an integer multiple of SEG
- SEG, 8, segment width resolved per stage; STAGES = WIDTH/SEG (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands/carry-in valid
- in_ready  output  1  stage 0 can accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in
- sub  input  1  subtract select (only with CIA_PIPE_SUB_EN)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR cout

One clock; reset is synchronous and active-low.

## Operation
- Per stage k (0..STAGES-1): register v[k], carry c[k], partial sum bits [k*SEG-1:0], remaining operand bits [WIDTH-1:k*SEG].
- Stage k computes segment k: p=a^b, g=a&b, prefix Gk/Pk over segment; segment carry-out = G + P·c_in_seg; sum bit i = p[i] ^ (G[0..i-1] + P[0..i-1]·c_in_seg); stage-0 c_in_seg = cin (or adjusted per Configuration).
- Carry into MSB captured in final stage for ovf.
- Handshake: transfer into stage k when v[k-1] & ready[k]; ready[k] = !v[k] | ready[k+1]; ready[STAGES] = out_ready. in_ready = ready[0]. Bubbles collapse.
- out_valid = v[STAGES-1]; sum/cout/ovf held stable while out_valid & !out_ready.
- Arithmetic: modulo 2^WIDTH; cout is unsigned carry; ovf per two's complement.
- a, b, cin, sub sampled only on in_valid & in_ready; ignored otherwise.

## Timing
- Reset (rst_n=0 at clk edge): all v[k]=0, all data registers 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 from the first cycle after reset (combinational, = 1 while pipeline empty).
- Reset mid-operation discards all in-flight operations; no partial result emitted.
- Latency: operation accepted at edge n appears with out_valid=1 after edge n+STAGES-1 (STAGES=1: registered once, visible after edge n).
- Full pipeline with out_ready=0: in_ready=0 same cycle (combinational path out_ready→in_ready).
- Full pipeline, out_ready=1, in_valid=1: simultaneous accept and emit, throughput 1/cycle.
- Carry wrap: 0xFFFF..F + 1 → sum=0, cout=1, ovf=0.

## Configuration
- CIA_PIPE_SUB_EN defined: sub accepted with operands; when sub=1 stage 0 uses ~b and carry-in (cin ^ 1)… precisely: b replaced by ~b and c_in_seg = ~cin (borrow-in convention: cin=0 gives a-b, cin=1 gives a-b-1); cout=1 means no borrow; sub travels with the operation.
- Not defined: sub port present but ignored; pure adder.

## Test plan
- WIDTH=16, SEG=4: reset, a=0x1234, b=0x4321, cin=0 → after 4 cycles sum=0x5555, cout=0, ovf=0; all outputs 0 during reset.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Back-to-back 100 random operations, out_ready=1 → one result per cycle, in order, matching a+b+cin.
- out_ready=0 for 6 cycles while feeding → exactly 4 accepted, in_ready=0 when full, held result stable; release → results drain in order, none lost/duplicated.
- Assert rst_n=0 with 3 operations in flight → out_valid=0 next cycle, no stale result after reset release.
- With CIA_PIPE_SUB_EN: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0; a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
